// File: rtl/tube_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with per-digit increment and clear.
// Each digit is driven for DWELL cycles, optionally followed by BLANK all-off cycles.
module tube_scan_ctrl #(
  parameter int DWELL = 50000,
  parameter int BLANK = 500
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_add,
  input  logic        i_clr,
  output logic [6:0]  o_digitalTube,
  output logic [3:0]  o_sel,
  output logic        o_frame,
  output logic [15:0] o_val
);

  typedef enum logic {S_SHOW, S_BLANK} state_t;

  localparam logic [19:0] DWELL_LAST = 20'(DWELL - 1);
  localparam logic [19:0] BLANK_LAST = 20'((BLANK > 0) ? (BLANK - 1) : 0);
  localparam bit          HAS_BLANK  = (BLANK > 0);

  state_t      state, state_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [19:0] cnt, cnt_nxt;
  logic [15:0] digits, digits_nxt;

  logic [3:0]  cur_digit;
  logic [6:0]  tube_nxt;
  logic [3:0]  sel_nxt;
  logic        frame_nxt;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Digit registers: clear wins over any simultaneous increments.
  always_comb begin
    digits_nxt = digits;
    if (i_clr) begin
      digits_nxt = 16'h0000;
    end else begin
      for (int k = 0; k < 4; k++) begin
        digits_nxt[4*k +: 4] = digits[4*k +: 4] + 4'(i_add[k]);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) digits <= 16'h0000;
    else        digits <= digits_nxt;
  end

  // Scan FSM: timing depends only on the counter, never on the digit inputs.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt + 20'd1;
    case (state)
      S_SHOW: begin
        if (cnt == DWELL_LAST) begin
          cnt_nxt = 20'd0;
          if (HAS_BLANK) state_nxt = S_BLANK;
          else           idx_nxt   = idx + 2'd1;
        end
      end
      S_BLANK: begin
        if (cnt == BLANK_LAST) begin
          cnt_nxt   = 20'd0;
          state_nxt = S_SHOW;
          idx_nxt   = idx + 2'd1;
        end
      end
      default: begin
        state_nxt = S_SHOW;
        cnt_nxt   = 20'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= S_SHOW;
      idx   <= 2'd0;
      cnt   <= 20'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    case (idx)
      2'd0:    cur_digit = digits[3:0];
      2'd1:    cur_digit = digits[7:4];
      2'd2:    cur_digit = digits[11:8];
      default: cur_digit = digits[15:12];
    endcase
  end

  // Select and pattern come from the same snapshot, so they always switch together.
  always_comb begin
    sel_nxt   = 4'b0000;
    tube_nxt  = 7'h00;
    frame_nxt = 1'b0;
    if (state == S_SHOW) begin
      sel_nxt   = 4'b0001 << idx;
      tube_nxt  = hex_decode(cur_digit);
      frame_nxt = (idx == 2'd3) && (cnt == DWELL_LAST);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_digitalTube <= 7'h00;
      o_sel         <= 4'b0000;
      o_frame       <= 1'b0;
      o_val         <= 16'h0000;
    end else begin
      o_digitalTube <= tube_nxt;
      o_sel         <= sel_nxt;
      o_frame       <= frame_nxt;
      o_val         <= digits;
    end
  end

endmodule

// File: tb/tb_tube_scan_ctrl.sv
// Bench for tube_scan_ctrl: a DWELL=4/BLANK=2 instance and a DWELL=4/BLANK=0 instance
// share stimulus and are checked every cycle against a time-based scan model.
module tb_tube_scan_ctrl;

  localparam int D = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  i_add;
  logic        i_clr;
  logic [6:0]  tube_a, tube_b;
  logic [3:0]  sel_a, sel_b;
  logic        frame_a, frame_b;
  logic [15:0] val_a, val_b;

  tube_scan_ctrl #(.DWELL(D), .BLANK(2)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_add(i_add), .i_clr(i_clr),
    .o_digitalTube(tube_a), .o_sel(sel_a), .o_frame(frame_a), .o_val(val_a)
  );

  tube_scan_ctrl #(.DWELL(D), .BLANK(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_add(i_add), .i_clr(i_clr),
    .o_digitalTube(tube_b), .o_sel(sel_b), .o_frame(frame_b), .o_val(val_b)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [6:0] seg [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_tests = 0;
  int n_fail  = 0;
  int t       = -1;      // cycles since reset release, -1 while in reset
  int mdig [4];
  logic [15:0] old_val;

  typedef struct {
    logic [3:0]  add;
    logic        clr;
    logic [15:0] exp_val;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask

  // Expected {frame, sel, tube} from the position in the scan period.
  function automatic logic [11:0] scan_exp(input int tt, input int b, input logic [15:0] digs);
    int p, ph, dig, w;
    logic [3:0] sel;
    logic [6:0] tube;
    logic       frame;
    sel = 4'b0000; tube = 7'h00; frame = 1'b0;
    if (tt >= 0) begin
      p   = D + b;
      ph  = tt % (4 * p);
      dig = ph / p;
      w   = ph % p;
      if (w < D) begin
        sel   = 4'(1 << dig);
        tube  = seg[digs[dig*4 +: 4]];
        frame = (dig == 3) && (w == D - 1);
      end
    end
    return {frame, sel, tube};
  endfunction

  // driver: one clock with the given pulse, model update, then full compare
  task automatic cycle(input logic [3:0] add, input logic clr);
    logic [11:0] ea, eb;
    i_add = add;
    i_clr = clr;
    @(posedge clk);
    if (!rst) begin
      t = -1;
      for (int k = 0; k < 4; k++) mdig[k] = 0;
      old_val = 16'h0000;
    end else begin
      t++;
      for (int k = 0; k < 4; k++) old_val[4*k +: 4] = 4'(mdig[k]);
      for (int k = 0; k < 4; k++) begin
        if (clr)         mdig[k] = 0;
        else if (add[k]) mdig[k] = (mdig[k] + 1) % 16;
      end
    end
    #1;
    i_add = 4'b0000;
    i_clr = 1'b0;
    ea = scan_exp(t, 2, old_val);
    eb = scan_exp(t, 0, old_val);
    check("sel_a",   32'(sel_a),   32'(ea[10:7]));
    check("tube_a",  32'(tube_a),  32'(ea[6:0]));
    check("frame_a", 32'(frame_a), 32'(ea[11]));
    check("val_a",   32'(val_a),   32'(old_val));
    check("sel_b",   32'(sel_b),   32'(eb[10:7]));
    check("tube_b",  32'(tube_b),  32'(eb[6:0]));
    check("frame_b", 32'(frame_b), 32'(eb[11]));
  endtask

  vec_t vecs [7];

  initial begin
    int n, first_frame;
    vecs[0] = '{4'b0001, 1'b0, 16'h0001};
    vecs[1] = '{4'b0001, 1'b0, 16'h0002};
    vecs[2] = '{4'b0001, 1'b0, 16'h0003};
    vecs[3] = '{4'b1000, 1'b0, 16'h1003};
    vecs[4] = '{4'b1111, 1'b1, 16'h0000};
    vecs[5] = '{4'b1111, 1'b0, 16'h1111};
    vecs[6] = '{4'b0000, 1'b1, 16'h0000};

    rst = 1'b0; i_add = 4'b0000; i_clr = 1'b0; old_val = 16'h0000;
    for (int k = 0; k < 4; k++) mdig[k] = 0;
    repeat (3) cycle(4'b0000, 1'b0);

    // release: first cycle shows digit 0 as 0
    rst = 1'b1;
    cycle(4'b0000, 1'b0);
    check("rel_sel", 32'(sel_a), 32'h1);
    check("rel_tube", 32'(tube_a), 32'h3F);
    repeat (47) cycle(4'b0000, 1'b0);

    // digit value vectors
    for (int i = 0; i < 7; i++) begin
      cycle(vecs[i].add, vecs[i].clr);
      cycle(4'b0000, 1'b0);
      check("tbl_val", 32'(val_a), 32'(vecs[i].exp_val));
    end

    // digit 2 wrap through F back to 0
    for (int i = 1; i <= 16; i++) begin
      cycle(4'b0100, 1'b0);
      cycle(4'b0000, 1'b0);
      check("wrap_val", 32'(val_a[11:8]), 32'(i % 16));
      if (i >= 15) begin
        n = 0;
        while (sel_a != 4'b0100 && n < 30) begin
          cycle(4'b0000, 1'b0);
          n++;
        end
        check("wrap_wait", 32'(n < 30), 32'h1);
        check("wrap_tube", 32'(tube_a), (i == 15) ? 32'h71 : 32'h3F);
      end
    end

    // random pulses against the model
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
            ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0);
    end

    // reset in the 2nd SHOW cycle of idx=2
    n = 0;
    while ((t % 24) != 13 && n < 30) begin
      cycle(4'($urandom_range(0, 15)), 1'b0);
      n++;
    end
    check("rst_wait", 32'(n < 30), 32'h1);
    rst = 1'b0;
    #1;
    check("rst_sel", 32'(sel_a), 32'h0);
    check("rst_tube", 32'(tube_a), 32'h0);
    check("rst_frame", 32'(frame_a), 32'h0);
    check("rst_val", 32'(val_a), 32'h0);
    repeat (2) cycle(4'b0000, 1'b0);
    rst = 1'b1;
    first_frame = -1;
    for (int i = 0; i < 30; i++) begin
      cycle(4'b0000, 1'b0);
      if (frame_a && first_frame < 0) first_frame = t;
    end
    check("rst_first_frame", 32'(first_frame), 32'd21);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
